one_inv_round: RTL and testbench
================================

// Module: one_inv_round
// PURPOSE
//  One AES inverse-cipher round, the decrypt-side counterpart of the table-driven
//  encrypt round: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
//  A per-beat flag skips InvMixColumns for the final round.
//  Two-stage pipeline with valid/ready on both sides; accepts 1 state/cycle.
//  Sits in the decrypt datapath, driven by the round controller with reversed round keys.
// PARAMETERS
//  none. Widths are fixed: 128-bit state/key, 8-bit S-box.
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    reset; one clock, asynchronous, active-low
//  in_valid   in   1    state_in/key/last are valid
//  in_ready   out  1    block accepts a beat this cycle
//  state_in   in   128  ciphertext-side state, byte0 = [127:120], column-major (FIPS-197)
//  key        in   128  round key for this round, same byte order
//  last       in   1    1 = final round: omit InvMixColumns
//  out_valid  out  1    state_out is valid
//  out_ready  in   1    consumer accepts state_out this cycle
//  state_out  out  128  round result, same byte order
// BEHAVIOUR
//  - Byte b[4c+r] is row r, column c. InvShiftRows: out[r][c] = in[r][(c-r) mod 4].
//  - Stage 1 (S1): on accept, register InvSubBytes(InvShiftRows(state_in)), key, last.
//    Inverse S-box is a 256x8 combinational ROM, replicated 16x.
//  - Stage 2 (S2): t = S1.data ^ S1.key; when last=0, register InvMixColumns(t) as state_out.
//    Column matrix rows: {0e 0b 0d 09}, rotated per row, in GF(2^8) mod 0x11b.
//    When last=1, register t unchanged.
//  - Accept = in_valid & in_ready. Output handoff = out_valid & out_ready.
//  - s2_adv = s1_v & (~out_valid | out_ready). in_ready = ~s1_v | s2_adv (combinational).
//  - Latency: beat accepted at edge N gives out_valid=1 after edge N+1 (2 regs).
//    Data presented cycle N is visible at the output from cycle N+2.
//  - Full throughput: with out_ready held 1, one result per cycle, no bubbles.
//  - Backpressure: out_ready=0 with out_valid=1 holds state_out stable.
//    S1 then fills and in_ready drops. No beat is lost or duplicated.
//  - When out_ready=1 and a full S1 are both present in one cycle, the output is
//    handed off and S1 moves to S2 on the same edge. S1 reloads on that edge if in_valid=1.
//  - Reset (async assert, any time incl. mid-flight): s1_v=0, out_valid=0,
//    state_out=0, internal regs=0. In-flight beats are discarded.
//    in_ready=1 from the first cycle after deassert.
//  - Data regs load only on their stage-advance enable; they hold otherwise.
//  - Inputs are ignored when in_valid=0. last is sampled per beat, not sticky.
// TESTING
//  1 state=all 0x63, key={8e4da1bc}x4, last=0 -> state_out={db135345}x4.
//  2 same stimulus, last=1 -> state_out={8e4da1bc}x4.
//    Also: state=0, key=0, last=0 or 1 -> all 0x52.
//  3 Full inverse-S-box sweep: every byte value in one lane, key=0, last=1.
//    Check against the golden table: 00->52, 63->00, ff->7d.
//  4 FIPS-197 App. C.1 AES-128: chain 10 rounds, last=1 on round 0, via a controller stub.
//    Ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff.
//  5 Stream 8 beats back-to-back with out_ready=1.
//    Check in_ready never drops, outputs are in order, and latency is 2.
//    Repeat with out_ready toggling 1010...: no loss or duplication; state_out is stable while stalled.
//  6 Assert rst_n low mid-stream with S1 and S2 full.
//    out_valid falls immediately and state_out=0. After release the next beat has correct latency and data.

Source files
------------

// File: rtl/one_inv_round.sv
`timescale 1ns/1ps
// One AES inverse-cipher round (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) as a
// two-stage valid/ready pipeline; a per-beat last flag skips InvMixColumns for the final round.
module one_inv_round (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] key,
    input  logic         last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    // Entry for byte value v lives at index ~v, so the literal reads in natural table order.
    localparam logic [255:0][7:0] InvSbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a;
        logic [7:0] x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a     = col[31-8*i -: 8];
            x2    = xt(a);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    logic         s1_v;
    logic [127:0] s1_data;
    logic [127:0] s1_key;
    logic         s1_last;
    logic         s2_adv;
    logic         accept;
    logic [127:0] sub_bytes;
    logic [127:0] t;
    logic [127:0] mixed;

    assign s2_adv   = s1_v & (~out_valid | out_ready);
    assign in_ready = ~s1_v | s2_adv;
    assign accept   = in_valid & in_ready;

    // Row r rotates right by r: destination column c takes source column (c - r) mod 4.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int Src = 4 * ((c - r + 4) % 4) + r;
            localparam int Dst = 4 * c + r;
            assign sub_bytes[127-8*Dst -: 8] = InvSbox[~state_in[127-8*Src -: 8]];
        end
        assign mixed[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
    end

    assign t = s1_data ^ s1_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                s1_v <= 1'b1;
            end else if (s2_adv) begin
                s1_v <= 1'b0;
            end
            if (s2_adv) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data   <= '0;
            s1_key    <= '0;
            s1_last   <= 1'b0;
            state_out <= '0;
        end else begin
            if (accept) begin
                s1_data <= sub_bytes;
                s1_key  <= key;
                s1_last <= last;
            end
            if (s2_adv) begin
                state_out <= s1_last ? t : mixed;
            end
        end
    end

endmodule

// File: tb/tb_one_inv_round.sv
`timescale 1ns/1ps
// Directed bench for one_inv_round: known-answer vectors, S-box sweep, FIPS-197 decrypt chain,
// streaming with and without backpressure, and reset while the pipeline is full.
module tb_one_inv_round;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] key;
    logic         last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [7:0]   sb      [256];
    logic [7:0]   inv_tab [256];
    logic [127:0] rk      [11];

    one_inv_round dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .key       (key),
        .last      (last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Forward S-box from field inverse plus affine map; inverse table by inversion.
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb[x]      = s;
            inv_tab[s] = 8'(x);
        end
    endtask

    task automatic expand_key(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic l);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   m [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b[4*c+r] = inv_tab[a[4*((c - r + 4) % 4) + r]] ^ k[127-8*(4*c+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                m[4*c+r] = l ? b[4*c+r] :
                    gf_mul(8'h0e, b[4*c+r]) ^ gf_mul(8'h0b, b[4*c+(r+1)%4]) ^
                    gf_mul(8'h0d, b[4*c+(r+2)%4]) ^ gf_mul(8'h09, b[4*c+(r+3)%4]);
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = m[i];
        return res;
    endfunction

    // Drives one beat into an idle pipeline; lat = negedges until out_valid, -1 on timeout.
    task automatic run_beat(input logic [127:0] s, input logic [127:0] k, input logic l,
                            output logic [127:0] res, output int lat);
        @(negedge clk);
        state_in  = s;
        key       = k;
        last      = l;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = -1;
        res      = '0;
        for (int i = 1; i <= 8; i++) begin
            if (out_valid) begin
                res = state_out;
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
        key       = '0;
        last      = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        vectors++;
        if (state_out !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_state_out: got %h want 0", state_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_known_answer();
        logic [127:0] st   [4];
        logic [127:0] ky   [4];
        logic         ls   [4];
        logic [127:0] want [4];
        logic [127:0] res;
        int           lat;
        st[0] = {16{8'h63}}; ky[0] = {4{32'h8e4da1bc}}; ls[0] = 1'b0; want[0] = {4{32'hdb135345}};
        st[1] = {16{8'h63}}; ky[1] = {4{32'h8e4da1bc}}; ls[1] = 1'b1; want[1] = {4{32'h8e4da1bc}};
        st[2] = '0;          ky[2] = '0;                ls[2] = 1'b0; want[2] = {16{8'h52}};
        st[3] = '0;          ky[3] = '0;                ls[3] = 1'b1; want[3] = {16{8'h52}};
        for (int i = 0; i < 4; i++) begin
            run_beat(st[i], ky[i], ls[i], res, lat);
            vectors++;
            if (lat != 2) begin
                miscompares++;
                $display("FAIL kat_latency[%0d]: got %0d want 2", i, lat);
            end
            vectors++;
            if (res !== want[i]) begin
                miscompares++;
                $display("FAIL kat_data[%0d]: got %h want %h", i, res, want[i]);
            end
        end
    endtask

    task automatic test_sbox_sweep();
        logic [127:0] res;
        logic [127:0] want;
        logic [7:0]   gold;
        int           lat;
        for (int v = 0; v < 256; v++) begin
            run_beat({8'(v), 120'h0}, '0, 1'b1, res, lat);
            want = {inv_tab[v], {15{8'h52}}};
            vectors++;
            if (lat != 2 || res !== want) begin
                miscompares++;
                $display("FAIL sbox[%02h]: got %h (lat %0d) want %h", v, res, lat, want);
            end
            if (v == 8'h00 || v == 8'h63 || v == 8'hff) begin
                gold = (v == 8'h00) ? 8'h52 : (v == 8'h63) ? 8'h00 : 8'h7d;
                vectors++;
                if (res[127:120] !== gold) begin
                    miscompares++;
                    $display("FAIL sbox_gold[%02h]: got %h want %h", v, res[127:120], gold);
                end
            end
        end
    endtask

    task automatic test_aes_chain();
        logic [127:0] s;
        logic [127:0] res;
        logic [127:0] want;
        int           lat;
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        s = 128'h69c4e0d86a7b0430d8cdb78070b4c55a ^ rk[10];
        for (int r = 9; r >= 0; r--) begin
            want = ref_round(s, rk[r], r == 0);
            run_beat(s, rk[r], r == 0, res, lat);
            vectors++;
            if (lat != 2 || res !== want) begin
                miscompares++;
                $display("FAIL aes_round[%0d]: got %h (lat %0d) want %h", r, res, lat, want);
            end
            s = res;
        end
        vectors++;
        if (s !== 128'h00112233445566778899aabbccddeeff) begin
            miscompares++;
            $display("FAIL aes_plaintext: got %h want 00112233445566778899aabbccddeeff", s);
        end
    endtask

    // stall=0: out_ready held high; stall=1: out_ready toggles 1,0,1,0...
    task automatic test_stream(input bit stall);
        logic [127:0] st   [8];
        logic [127:0] ky   [8];
        logic         ls   [8];
        logic [127:0] want [8];
        int           drv_cyc [8];
        int           idx;
        int           n_out;
        bit           held;
        logic [127:0] held_val;
        for (int i = 0; i < 8; i++) begin
            st[i]   = {$urandom, $urandom, $urandom, $urandom};
            ky[i]   = {$urandom, $urandom, $urandom, $urandom};
            ls[i]   = (i % 3 == 0);
            want[i] = ref_round(st[i], ky[i], ls[i]);
        end
        idx      = 0;
        n_out    = 0;
        held     = 1'b0;
        held_val = '0;
        for (int t = 0; t < 64 && n_out < 8; t++) begin
            @(negedge clk);
            out_ready = stall ? (t % 2 == 0) : 1'b1;
            if (idx < 8) begin
                state_in = st[idx];
                key      = ky[idx];
                last     = ls[idx];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held) begin
                vectors++;
                if (out_valid !== 1'b1 || state_out !== held_val) begin
                    miscompares++;
                    $display("FAIL stall_hold: got v=%b %h want v=1 %h", out_valid, state_out,
                             held_val);
                end
            end
            held = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    vectors++;
                    if (state_out !== want[n_out]) begin
                        miscompares++;
                        $display("FAIL stream%0d_data[%0d]: got %h want %h", stall, n_out,
                                 state_out, want[n_out]);
                    end
                    if (!stall) begin
                        vectors++;
                        if (cyc - drv_cyc[n_out] != 2) begin
                            miscompares++;
                            $display("FAIL stream_latency[%0d]: got %0d want 2", n_out,
                                     cyc - drv_cyc[n_out]);
                        end
                    end
                    n_out++;
                end else begin
                    held     = 1'b1;
                    held_val = state_out;
                end
            end
            if (!stall) begin
                vectors++;
                if (in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stream_in_ready[t=%0d]: got %b want 1", t, in_ready);
                end
            end
            if (in_valid && in_ready) begin
                drv_cyc[idx] = cyc;
                idx++;
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (n_out != 8) begin
            miscompares++;
            $display("FAIL stream%0d_count: got %0d want 8", stall, n_out);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream%0d_dup: got out_valid=%b want 0", stall, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] a_s;
        logic [127:0] b_s;
        logic [127:0] c_s;
        logic [127:0] k;
        logic [127:0] res;
        logic [127:0] want;
        int           lat;
        a_s = 128'h0123456789abcdeffedcba9876543210;
        b_s = 128'hdeadbeef00112233cafef00d44556677;
        c_s = 128'h3243f6a8885a308d313198a2e0370734;
        k   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        @(negedge clk);
        out_ready = 1'b0;
        state_in  = a_s;
        key       = k;
        last      = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        state_in = b_s;
        last     = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        want = ref_round(a_s, k, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || state_out !== want) begin
            miscompares++;
            $display("FAIL full_before_reset: got v=%b rdy=%b %h want v=1 rdy=0 %h", out_valid,
                     in_ready, state_out, want);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || state_out !== 128'h0) begin
            miscompares++;
            $display("FAIL mid_reset_out: got v=%b %h want v=0 0", out_valid, state_out);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_beat(c_s, k, 1'b0, res, lat);
        want = ref_round(c_s, k, 1'b0);
        vectors++;
        if (lat != 2 || res !== want) begin
            miscompares++;
            $display("FAIL after_reset_beat: got %h (lat %0d) want %h (lat 2)", res, lat, want);
        end
    endtask

    initial begin
        build_tables();
        test_reset();
        test_known_answer();
        test_sbox_sweep();
        test_aes_chain();
        test_stream(1'b0);
        test_stream(1'b1);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
